// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Holds the power-up pattern and the pattern-length legality check.
package seq_det_pkg;

    localparam logic [3:0] DEFAULT_PAT = 4'b1011;
    localparam int         DEFAULT_LEN = 4;

    function automatic logic len_ok(input int unsigned len, input int unsigned max);
        return (len >= 1) && (len <= max);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// When clear and increment arrive together the count restarts at 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap control, input qualifier,
// registered Moore match flag and saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x,
    input  logic               in_valid,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               matched_q, matched_d;
    logic               cfg_err_q;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               len_legal;
    logic               valid_edge;
    logic               hit;

    assign len_legal  = len_ok(32'(pat_len), 32'(MAX_LEN));
    assign valid_edge = in_valid && !load;
    assign hist_shift = {hist_q[MAX_LEN-2:0], x};
    assign fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;

    // Only the low len_q history bits take part in the compare.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign mask[gi] = (LEN_W'(gi) < len_q);
        end
    endgenerate

    assign hit = valid_edge && (fill_inc >= len_q) &&
                 ((hist_shift & mask) == (pat_q & mask));

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        matched_d = matched_q;
        if (load) begin
            if (len_legal) begin
                hist_d    = '0;
                fill_d    = '0;
                matched_d = 1'b0;
            end
        end else if (in_valid) begin
            hist_d    = hist_shift;
            matched_d = hit;
            fill_d    = (hit && !overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= MAX_LEN'(DEFAULT_PAT);
            len_q     <= LEN_W'(DEFAULT_LEN);
            hist_q    <= '0;
            fill_q    <= '0;
            matched_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            if (load && len_legal) begin
                pat_q <= pat;
                len_q <= pat_len;
            end
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            matched_q <= matched_d;
            cfg_err_q <= load && !len_legal;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (hit),
        .count (match_count)
    );

    assign z       = matched_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 3;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               x = 1'b0;
    logic               in_valid = 1'b0;
    logic               load = 1'b0;
    logic [MAX_LEN-1:0] pat = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap = 1'b1;
    logic               cnt_clr = 1'b0;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .in_valid    (in_valid),
        .load        (load),
        .pat         (pat),
        .pat_len     (pat_len),
        .overlap     (overlap),
        .cnt_clr     (cnt_clr),
        .z           (z),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit z;
        int cnt;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: bits received since the last clear, oldest first.
    bit             m_bits[$];
    bit [7:0]       m_pat;
    int             m_len;
    int             m_cnt;
    bit             m_z;
    bit             m_err;

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (txn %0d)", name, act, req, txn);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat = 8'b0000_1011;
        m_len = 4;
        m_cnt = 0;
        m_z   = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        bit hit;
        bit legal;
        hit   = 1'b0;
        legal = (pat_len >= 1) && (int'(pat_len) <= MAX_LEN);
        m_err = load && !legal;
        if (load) begin
            if (legal) begin
                m_pat = pat;
                m_len = int'(pat_len);
                m_bits.delete();
                m_z = 1'b0;
            end
        end else if (in_valid) begin
            m_bits.push_back(x);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            m_z = hit;
            if (hit && !overlap) m_bits.delete();
        end
        if (cnt_clr) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic step(input bit xb, input bit vb, input bit ldb,
                        input bit [7:0] p, input int l, input bit ovb, input bit clrb);
        x        = xb;
        in_valid = vb;
        load     = ldb;
        pat      = p;
        pat_len  = LEN_W'(l);
        overlap  = ovb;
        cnt_clr  = clrb;
        @(posedge clk);
        model_edge();
        #1;
        sb.push_back('{z: m_z, cnt: m_cnt, err: m_err});
        @(negedge clk);
    endtask

    task automatic bit_in(input bit xb, input bit ovb);
        step(xb, 1'b1, 1'b0, 8'h00, 0, ovb, 1'b0);
    endtask

    task automatic gap(input bit ovb);
        step(1'b0, 1'b0, 1'b0, 8'h00, 0, ovb, 1'b0);
    endtask

    task automatic do_load(input bit [7:0] p, input int l);
        step(1'b1, 1'b1, 1'b1, p, l, 1'b1, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        cmp("async_rst_z", int'(z), 0);
        cmp("async_rst_cnt", int'(match_count), 0);
        cmp("async_rst_err", int'(cfg_err), 0);
        model_reset();
        @(posedge clk);
        #1;
        sb.push_back('{z: 1'b0, cnt: 0, err: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            txn++;
            $display("txn %0d: z=%0b cnt=%0d err=%0b (exp z=%0b cnt=%0d err=%0b)",
                     txn, z, match_count, cfg_err, e.z, e.cnt, e.err);
            cmp("z", int'(z), int'(e.z));
            cmp("match_count", int'(match_count), e.cnt);
            cmp("cfg_err", int'(cfg_err), int'(e.err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [10:0] s1;
        bit [6:0]  s2;
        bit [6:0]  s3;
        bit        ov;
        s1 = 11'b11011011011;
        s2 = 7'b1011011;
        s3 = 7'b1110110;

        @(negedge clk);
        do_reset();

        // Default 1011, overlapping then non-overlapping.
        for (int i = 10; i >= 0; i--) bit_in(s1[i], 1'b1);
        do_reset();
        for (int i = 10; i >= 0; i--) bit_in(s1[i], 1'b0);
        do_reset();
        for (int i = 6; i >= 0; i--) bit_in(s2[i], 1'b0);

        // Loaded pattern 110, then an illegal length that must change nothing.
        do_load(8'b110, 3);
        for (int i = 6; i >= 0; i--) bit_in(s3[i], 1'b1);
        do_load(8'hFF, 0);
        do_load(8'hFF, 9);
        for (int i = 6; i >= 0; i--) bit_in(s3[i], 1'b1);

        // in_valid gaps with the default pattern; z holds across gaps.
        do_reset();
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
        gap(1'b1); gap(1'b1);
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
        gap(1'b1); gap(1'b1); gap(1'b1);

        // Saturation with a single-bit pattern, then clear with and without a hit.
        do_load(8'b1, 1);
        repeat (10) bit_in(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1);

        // Reset mid-stream after 1,0,1; a lone 1 afterwards must not match.
        do_load(8'b1011, 4);
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        do_reset();
        bit_in(1'b1, 1'b1);

        // Randomised traffic against the reference model.
        ov = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            if ((n % 25) == 0) ov = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                int l;
                l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(1, 4));
                step(1'($urandom), 1'($urandom), 1'b1, 8'($urandom), l, ov,
                     ($urandom_range(0, 19) == 0));
            end else begin
                step(1'($urandom), (r < 80), 1'b0, 8'h00, 0, ov,
                     ($urandom_range(0, 19) == 0));
            end
        end

        repeat (3) @(negedge clk);
        cmp("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
